// File: rtl/core_mul_issue.sv
`default_nettype none
// ============================================================================
// Module      : core_mul_issue
// Description : Issue/writeback sequencer in front of the iterative multiplier
//               core_mul. Optional zero-operand bypass: MUL_ZERO_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module core_mul_issue #(
    parameter int W     = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_a,
    input  logic [W-1:0]       in_b,
    input  logic               in_signed,
    input  logic               in_high,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic               flush,
    output logic               mul_start,
    output logic [W-1:0]       mul_a,
    output logic [W-1:0]       mul_b,
    input  logic [2*W-1:0]     mul_q,
    input  logic               mul_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t             state_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               signed_q;
    logic               high_q;
    logic [TAG_W-1:0]   tag_q;
    logic               mul_start_q;
    logic               out_valid_q;
    logic [W-1:0]       out_data_q;
    logic [TAG_W-1:0]   out_tag_q;

    logic [2*W-1:0]     prod_d;
    logic [W-1:0]       res_d;
    logic               accept_d;

    // The multiplier always returns a signed product; an operand with its MSB
    // set was read as negative, so add the other operand back at weight 2^W.
    always_comb begin
        prod_d = mul_q;
        if (!signed_q) begin
            if (a_q[W-1]) prod_d = prod_d + {b_q, {W{1'b0}}};
            if (b_q[W-1]) prod_d = prod_d + {a_q, {W{1'b0}}};
        end
        res_d = high_q ? prod_d[2*W-1:W] : prod_d[W-1:0];
    end

    assign in_ready = (state_q == S_IDLE) && !rst && !flush;
    assign accept_d = in_valid && in_ready;

`ifdef MUL_ZERO_BYPASS_EN
    logic zero_d;
    assign zero_d = (in_a == '0) || (in_b == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            signed_q    <= 1'b0;
            high_q      <= 1'b0;
            tag_q       <= '0;
            mul_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        signed_q <= in_signed;
                        high_q   <= in_high;
                        tag_q    <= in_tag;
`ifdef MUL_ZERO_BYPASS_EN
                        if (zero_d) begin
                            out_data_q  <= '0;
                            out_tag_q   <= in_tag;
                            out_valid_q <= 1'b1;
                            state_q     <= S_HOLD;
                        end else begin
                            mul_start_q <= 1'b1;
                            state_q     <= S_ISSUE;
                        end
`else
                        mul_start_q <= 1'b1;
                        state_q     <= S_ISSUE;
`endif
                    end
                end
                // The start pulse has already gone out this cycle, so a flush
                // here still has to wait for the multiplier to finish.
                S_ISSUE: begin
                    mul_start_q <= 1'b0;
                    state_q     <= flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (flush) begin
                        state_q <= S_DRAIN;
                    end else if (mul_ready) begin
                        out_data_q  <= res_d;
                        out_tag_q   <= tag_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_HOLD;
                    end
                end
                S_DRAIN: begin
                    if (mul_ready) state_q <= S_IDLE;
                end
                S_HOLD: begin
                    if (flush || out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    mul_start_q <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign mul_start = mul_start_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_core_mul_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_mul_issue
// Description : Scoreboard bench for core_mul_issue with a behavioural core_mul.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_mul_issue;
    localparam int W  = 16;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_a = '0;
    logic [W-1:0]    in_b = '0;
    logic            in_signed = 1'b0;
    logic            in_high = 1'b0;
    logic [TW-1:0]   in_tag = '0;
    logic            flush = 1'b0;
    logic            mul_start;
    logic [W-1:0]    mul_a;
    logic [W-1:0]    mul_b;
    logic [2*W-1:0]  mul_q = '0;
    logic            mul_ready = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_data;
    logic [TW-1:0]   out_tag;
    logic            busy;

    always #5 clk = ~clk;

    core_mul_issue #(.W(W), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_high(in_high),
        .in_tag(in_tag), .flush(flush),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_q(mul_q), .mul_ready(mul_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .busy(busy)
    );

    typedef struct {
        logic [W-1:0]  d;
        logic [TW-1:0] t;
    } exp_t;

    exp_t sbq[$];
    int   tot = 0;
    int   bad = 0;
    int   starts_seen = 0;
    int   starts_exp = 0;
    int   fixed_lat = 0;
    int   or_mode = 0;     // 0 random, 1 hold low, 2 hold high
    logic acc_zero = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: full-precision product of the operands as integers.
    function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s, input logic h);
        longint pa, pb;
        logic [63:0] p;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        p  = pa * pb;
        return h ? p[2*W-1:W] : p[W-1:0];
    endfunction

    // Behavioural core_mul: signed product after a variable latency.
    initial begin
        logic signed [W-1:0] ca, cb;
        int lat;
        forever begin
            @(negedge clk);
            if (mul_start === 1'b1) begin
                ca  = mul_a;
                cb  = mul_b;
                lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 5));
                repeat (lat) @(posedge clk);
                #1;
                mul_q     = ca * cb;
                mul_ready = 1'b1;
                @(posedge clk);
                #1;
                mul_ready = 1'b0;
                mul_q     = $urandom;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = (or_mode == 0) ? 1'($urandom_range(0, 1)) : (or_mode == 2);
        end
    end

    // Output monitor: pops the scoreboard on every writeback handshake.
    initial begin
        logic prev_ov, prev_mr, prev_az, held;
        logic [W-1:0]  hd;
        logic [TW-1:0] ht;
        exp_t e;
        prev_ov = 0; prev_mr = 0; prev_az = 0; held = 0; hd = '0; ht = '0;
        forever begin
            @(negedge clk);
            #1;
            if (mul_start === 1'b1) starts_seen++;
            if (rst || flush) begin
                prev_ov = 0; held = 0; prev_az = 0; prev_mr = mul_ready;
            end else begin
                if (held) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, hd);
                    chk("hold_tag", out_tag, ht);
                end
                if (out_valid) begin
                    chk("in_ready_in_hold", in_ready, 0);
                    chk("busy_in_hold", busy, 1);
                    if (!prev_ov) chk("out_latency", prev_mr | prev_az, 1);
                    if (sbq.size() == 0) begin
                        tot++; bad++;
                        $display("FAIL spurious_out: got tag %0h want no result", out_tag);
                    end else if (out_ready) begin
                        e = sbq.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_tag", out_tag, e.t);
                    end
                end
                held    = out_valid && !out_ready;
                hd      = out_data;
                ht      = out_tag;
                prev_ov = out_valid;
                prev_mr = mul_ready;
                prev_az = acc_zero;
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic h, input logic [TW-1:0] t, input logic [W-1:0] expd);
        exp_t e;
        bit ok, byp;
        ok = 0; byp = 0;
        @(posedge clk); #1;
        in_a = a; in_b = b; in_signed = s; in_high = h; in_tag = t; in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok  = 1;
                e.d = expd;
                e.t = t;
                sbq.push_back(e);
`ifdef MUL_ZERO_BYPASS_EN
                byp = (a == '0) || (b == '0);
`endif
                if (byp) acc_zero = 1'b1;
                else     starts_exp++;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!ok) begin
            tot++; bad++;
            $display("FAIL accept_timeout: got no accept want accept");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_zero = 1'b0;
        if (ok) begin
            @(negedge clk);
            chk("start_after_accept", mul_start, !byp);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            tot++; bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
        chk("out_valid_seen", out_valid, 1);
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_in_ready"}, in_ready, 1);
        chk({p, "_mul_start"}, mul_start, 0);
        chk({p, "_mul_a"}, mul_a, 0);
        chk({p, "_mul_b"}, mul_b, 0);
        chk({p, "_out_valid"}, out_valid, 0);
        chk({p, "_out_data"}, out_data, 0);
        chk({p, "_out_tag"}, out_tag, 0);
        chk({p, "_busy"}, busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic rs, rh;
        logic [TW-1:0] rt;

        repeat (2) @(negedge clk);
        chk("in_ready_in_reset", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("por");

        // Directed products
        or_mode = 2;
        send(16'hFFFD, 16'h0005, 1, 0, 4'h1, 16'hFFF1);
        send(16'hFFFD, 16'h0005, 1, 1, 4'h2, 16'hFFFF);
        send(16'hFFFF, 16'hFFFF, 0, 1, 4'h3, 16'hFFFE);
        send(16'hFFFF, 16'hFFFF, 0, 0, 4'h4, 16'h0001);
        send(16'h8000, 16'h0002, 0, 1, 4'h5, 16'h0001);
        send(16'h8000, 16'h0002, 0, 0, 4'h6, 16'h0000);
        send(16'h0000, 16'h1234, 0, 0, 4'h7, 16'h0000);
        wait_drain();

        // Backpressure for 10 cycles
        or_mode = 1;
        send(16'h1234, 16'h0010, 0, 0, 4'h8, 16'h2340);
        wait_out_valid();
        repeat (10) @(negedge clk);
        or_mode = 2;
        @(negedge clk);
        chk("in_ready_at_handshake", in_ready, 0);
        @(negedge clk);
        chk("in_ready_after_handshake", in_ready, 1);
        send(16'h0011, 16'h0011, 0, 0, 4'h9, 16'h0121);
        wait_drain();

        // Flush during WAIT
        fixed_lat = 5;
        send(16'h0003, 16'h0004, 0, 0, 4'h5, 16'h000C);
        @(posedge clk); #1;
        flush = 1'b1;
        if (sbq.size() > 0) void'(sbq.pop_front());
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (12) @(negedge clk);
        chk("idle_after_drain", busy, 0);
        fixed_lat = 0;
        send(16'h0007, 16'h0006, 0, 0, 4'h6, 16'h002A);
        wait_drain();

        // Flush during HOLD
        or_mode = 1;
        send(16'h0005, 16'h0005, 0, 0, 4'hB, 16'h0019);
        wait_out_valid();
        @(posedge clk); #1;
        flush = 1'b1;
        if (sbq.size() > 0) void'(sbq.pop_front());
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("hold_flush_valid", out_valid, 0);
        chk("hold_flush_ready", in_ready, 1);
        or_mode = 2;

        // Flush in IDLE blocks a same-cycle request
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; in_a = 16'h0009; in_b = 16'h0009;
        @(negedge clk);
        chk("idle_flush_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("idle_flush_busy", busy, 0);

        // Reset in the middle of WAIT
        fixed_lat = 5;
        send(16'h0100, 16'h0100, 0, 1, 4'hA, 16'h0001);
        @(posedge clk); #1;
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk("in_ready_mid_reset", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_wait");
        repeat (12) @(negedge clk);
        fixed_lat = 0;

        // Randomised traffic with random writeback backpressure
        or_mode = 0;
        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            rs = 1'($urandom_range(0, 1));
            rh = 1'($urandom_range(0, 1));
            rt = TW'($urandom);
            send(ra, rb, rs, rh, rt, ref_res(ra, rb, rs, rh));
        end
        or_mode = 2;
        wait_drain();

        chk("start_count", starts_seen, starts_exp);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
`default_nettype wire
